// File: rtl/conv_top_system_pkg.sv
// Shared types and sizing helpers for the single-MAC convolution engine.
// Frame-dependent sizes are derived in the top from its parameters.
package conv_top_system_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadA,
    StCompute,
    StOutput,
    StDone
  } state_e;

  // Sizes for the default configuration (K=3, Cin=2, Cout=16).
  localparam int unsigned DefKernel = 3;
  localparam int unsigned DefCin    = 2;
  localparam int unsigned DefCout   = 16;
  localparam int unsigned TAPS      = DefKernel * DefKernel * DefCin;
  localparam int unsigned NW        = TAPS * DefCout;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_top_system_if.sv
// Activation/weight handshakes and the result stream of the convolution engine.
interface conv_top_system_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned XW = 7,
  parameter int unsigned YW = 7,
  parameter int unsigned CW = 4
);

  logic signed [DW-1:0] a_input;
  logic                 a_valid;
  logic                 a_ready;
  logic signed [DW-1:0] b_input;
  logic                 b_valid;
  logic                 b_ready;
  logic signed [DW-1:0] out;
  logic                 output_valid;
  logic [XW-1:0]        output_x;
  logic [YW-1:0]        output_y;
  logic [CW-1:0]        output_ch;

  modport master (
    output a_input, a_valid, b_input, b_valid,
    input  a_ready, b_ready, out, output_valid, output_x, output_y, output_ch
  );

  modport slave (
    input  a_input, a_valid, b_input, b_valid,
    output a_ready, b_ready, out, output_valid, output_x, output_y, output_ch
  );

endinterface

// File: rtl/conv_top_system_mac.sv
// Signed multiply-accumulate with clear; res is the low part of the next accumulator value.
module conv_mac #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AccWidth  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic signed [DataWidth-1:0] a,
  input  logic signed [DataWidth-1:0] b,
  output logic signed [DataWidth-1:0] res
);

  localparam int unsigned PW = 2 * DataWidth;

  logic signed [PW-1:0]       a_ext, b_ext, prod;
  logic signed [AccWidth-1:0] prod_ext, base, acc_d, acc_q;

  assign a_ext    = PW'(a);
  assign b_ext    = PW'(b);
  assign prod     = a_ext * b_ext;
  assign prod_ext = AccWidth'(prod);
  // clr restarts the sum with this cycle's product, so no idle clear cycle is needed.
  assign base     = clr ? '0 : acc_q;
  assign acc_d    = en ? base + prod_ext : acc_q;
  assign res      = acc_d[DataWidth-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/conv_top_system.sv
// Single-MAC 2-D convolution engine: loads weights, streams a sliding K x K x Cin patch,
// and emits one result per output channel per pixel with zero padding at the frame edges.
module conv_top_system
  import conv_top_system_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned ACCUMULATION_WIDTH = 32,
  parameter int unsigned EXT_MEM_HEIGHT     = 256,
  parameter int unsigned EXT_MEM_WIDTH      = 32,
  parameter int unsigned FEATURE_MAP_WIDTH  = 128,
  parameter int unsigned FEATURE_MAP_HEIGHT = 128,
  parameter int unsigned INPUT_NB_CHANNELS  = 2,
  parameter int unsigned OUTPUT_NB_CHANNELS = 16,
  parameter int unsigned KERNEL_SIZE        = 3
) (
  input  logic                    clk,
  input  logic                    arst_n_in,
  input  logic                    start,
  output logic                    running,
  conv_top_system_if.slave        bus,
  output logic                    int_mem_we,
  output logic                    overlap_cache_we,
  output logic                    data_ready,
  output logic                    fsm_done
);

  localparam int unsigned K    = KERNEL_SIZE;
  localparam int unsigned Cin  = INPUT_NB_CHANNELS;
  localparam int unsigned Cout = OUTPUT_NB_CHANNELS;
  localparam int unsigned W    = FEATURE_MAP_WIDTH;
  localparam int unsigned H    = FEATURE_MAP_HEIGHT;
  localparam int unsigned DW   = IO_DATA_WIDTH;
  localparam int unsigned Taps = K * K * Cin;
  localparam int unsigned NumW = Taps * Cout;
  localparam int          R    = int'(K / 2);
  localparam int unsigned XW   = cnt_width(W);
  localparam int unsigned YW   = cnt_width(H);
  localparam int unsigned CW   = cnt_width(Cout);
  localparam int unsigned KW   = cnt_width(K);
  localparam int unsigned CIW  = cnt_width(Cin);
  localparam int unsigned TW   = cnt_width(Taps);
  localparam int unsigned AW   = cnt_width(NumW);

  if (KERNEL_SIZE % 2 == 0 || EXT_MEM_HEIGHT == 0 || EXT_MEM_WIDTH == 0) begin : g_bad_params
    $error("conv_top_system: KERNEL_SIZE must be odd and EXT_MEM_* non-zero");
  end

  logic rst;
  assign rst = arst_n_in;

  state_e               state;
  logic [XW-1:0]        x, out_x;
  logic [YW-1:0]        y, out_y;
  logic [CW-1:0]        co, out_ch;
  logic [KW-1:0]        lky, lkx;
  logic [CIW-1:0]       lci;
  logic [TW-1:0]        ctap;
  logic [AW-1:0]        widx;
  logic                 la_init, a_ready_q, b_ready_q, out_valid_q;
  logic signed [DW-1:0] out_q, mac_a, mac_b, mac_res;

  logic signed [DW-1:0] wmem  [NumW];
  logic signed [DW-1:0] cache [Taps];

  int             ky_lo, ky_hi, kx_lo, kx_hi;
  logic           has_fetch, last_fetch, a_xfer, b_xfer;
  logic           cache_clear, cache_shift, cache_wr, mac_en, mac_clr;
  logic [TW-1:0]  cache_widx;

  assign bus.a_ready      = a_ready_q;
  assign bus.b_ready      = b_ready_q;
  assign bus.out          = out_q;
  assign bus.output_valid = out_valid_q;
  assign bus.output_x     = out_x;
  assign bus.output_y     = out_y;
  assign bus.output_ch    = out_ch;

  assign a_xfer = bus.a_valid & a_ready_q;
  assign b_xfer = bus.b_valid & b_ready_q;

  // In-bound taps of the current pixel form a rectangle; x>0 only refills column K-1.
  always_comb begin
    ky_lo = (R > int'(y)) ? R - int'(y) : 0;
    ky_hi = (int'(H) - 1 + R - int'(y) < int'(K) - 1) ? int'(H) - 1 + R - int'(y) : int'(K) - 1;
    if (x == '0) begin
      kx_lo = R;
      kx_hi = (int'(W) - 1 + R < int'(K) - 1) ? int'(W) - 1 + R : int'(K) - 1;
    end else begin
      kx_lo = int'(K) - 1;
      kx_hi = (int'(W) - 1 + R - int'(x) < int'(K) - 1) ? int'(W) - 1 + R - int'(x)
                                                        : int'(K) - 1;
    end
  end

  assign has_fetch  = (ky_lo <= ky_hi) && (kx_lo <= kx_hi);
  assign last_fetch = (lci == CIW'(Cin - 1)) && (int'(lkx) == kx_hi) && (int'(lky) == ky_hi);
  assign cache_widx = TW'((int'(lky) * int'(K) + int'(lkx)) * int'(Cin) + int'(lci));

  assign cache_clear = (state == StLoadA) && la_init && (x == '0);
  assign cache_shift = (state == StLoadA) && la_init && (x != '0);
  assign cache_wr    = (state == StLoadA) && a_xfer;
  assign mac_en      = (state == StCompute);
  assign mac_clr     = (ctap == '0);
  assign mac_a       = cache[ctap];
  assign mac_b       = wmem[widx];

  // Weight store: flat index co*Taps + (ky*K + kx)*Cin + ci matches the load order.
  always_ff @(posedge clk) begin
    if (b_xfer) begin
      wmem[widx] <= bus.b_input;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_clear) begin
      for (int i = 0; i < int'(Taps); i++) begin
        cache[i] <= '0;
      end
    end else if (cache_shift) begin
      for (int ky = 0; ky < int'(K); ky++) begin
        for (int kx = 0; kx < int'(K); kx++) begin
          for (int ci = 0; ci < int'(Cin); ci++) begin
            if (kx < int'(K) - 1) begin
              cache[(ky * int'(K) + kx) * int'(Cin) + ci] <=
                cache[(ky * int'(K) + kx + 1) * int'(Cin) + ci];
            end else begin
              cache[(ky * int'(K) + kx) * int'(Cin) + ci] <= '0;
            end
          end
        end
      end
    end else if (cache_wr) begin
      cache[cache_widx] <= bus.a_input;
    end
  end

  conv_mac #(
    .DataWidth(DW),
    .AccWidth (ACCUMULATION_WIDTH)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .en (mac_en),
    .clr(mac_clr),
    .a  (mac_a),
    .b  (mac_b),
    .res(mac_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= StIdle;
      running          <= 1'b0;
      int_mem_we       <= 1'b0;
      overlap_cache_we <= 1'b0;
      data_ready       <= 1'b0;
      fsm_done         <= 1'b0;
      out_valid_q      <= 1'b0;
      out_q            <= '0;
      out_x            <= '0;
      out_y            <= '0;
      out_ch           <= '0;
      a_ready_q        <= 1'b0;
      b_ready_q        <= 1'b0;
      la_init          <= 1'b0;
      x                <= '0;
      y                <= '0;
      co               <= '0;
      lky              <= '0;
      lkx              <= '0;
      lci              <= '0;
      ctap             <= '0;
      widx             <= '0;
    end else begin
      int_mem_we       <= 1'b0;
      overlap_cache_we <= 1'b0;
      data_ready       <= 1'b0;
      fsm_done         <= 1'b0;
      out_valid_q      <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state     <= StLoadW;
            running   <= 1'b1;
            b_ready_q <= 1'b1;
            widx      <= '0;
            x         <= '0;
            y         <= '0;
          end
        end
        StLoadW: begin
          if (b_xfer) begin
            int_mem_we <= 1'b1;
            if (widx == AW'(NumW - 1)) begin
              b_ready_q <= 1'b0;
              widx      <= '0;
              la_init   <= 1'b1;
              state     <= StLoadA;
            end else begin
              widx <= widx + 1'b1;
            end
          end
        end
        StLoadA: begin
          if (la_init) begin
            la_init <= 1'b0;
            lky     <= KW'(ky_lo);
            lkx     <= KW'(kx_lo);
            lci     <= '0;
            if (has_fetch) begin
              a_ready_q <= 1'b1;
            end else begin
              data_ready <= 1'b1;
            end
          end else if (data_ready) begin
            state <= StCompute;
            ctap  <= '0;
            co    <= '0;
            widx  <= '0;
          end else if (a_xfer) begin
            overlap_cache_we <= 1'b1;
            if (last_fetch) begin
              a_ready_q  <= 1'b0;
              data_ready <= 1'b1;
            end else if (lci != CIW'(Cin - 1)) begin
              lci <= lci + 1'b1;
            end else begin
              lci <= '0;
              if (int'(lkx) != kx_hi) begin
                lkx <= lkx + 1'b1;
              end else begin
                lkx <= KW'(kx_lo);
                lky <= lky + 1'b1;
              end
            end
          end
        end
        StCompute: begin
          widx <= widx + 1'b1;
          if (ctap == TW'(Taps - 1)) begin
            state       <= StOutput;
            out_valid_q <= 1'b1;
            out_q       <= mac_res;
            out_x       <= x;
            out_y       <= y;
            out_ch      <= co;
          end else begin
            ctap <= ctap + 1'b1;
          end
        end
        StOutput: begin
          if (co != CW'(Cout - 1)) begin
            co    <= co + 1'b1;
            ctap  <= '0;
            state <= StCompute;
          end else if (x != XW'(W - 1)) begin
            x       <= x + 1'b1;
            la_init <= 1'b1;
            state   <= StLoadA;
          end else if (y != YW'(H - 1)) begin
            x       <= '0;
            y       <= y + 1'b1;
            la_init <= 1'b1;
            state   <= StLoadA;
          end else begin
            x        <= '0;
            fsm_done <= 1'b1;
            state    <= StDone;
          end
        end
        StDone: begin
          running <= 1'b0;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_top_system.sv
// Directed bench for conv_top_system on a reduced 8x8 frame, Cin=2, Cout=4, K=3.
module tb_conv_top_system;

  localparam int W = 8, H = 8, CI = 2, CO = 4, K = 3, R = 1;
  localparam int TAPS = K * K * CI, NW = TAPS * CO;

  logic clk = 1'b0;
  logic rst, start, running, int_mem_we, overlap_cache_we, data_ready, fsm_done;

  always #5 clk = ~clk;

  conv_top_system_if #(.DW(16), .XW(3), .YW(3), .CW(2)) bus ();

  conv_top_system #(
    .FEATURE_MAP_WIDTH (W),
    .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS (CI),
    .OUTPUT_NB_CHANNELS(CO),
    .KERNEL_SIZE       (K)
  ) dut (
    .clk             (clk),
    .arst_n_in       (rst),
    .start           (start),
    .running         (running),
    .bus             (bus),
    .int_mem_we      (int_mem_we),
    .overlap_cache_we(overlap_cache_we),
    .data_ready      (data_ready),
    .fsm_done        (fsm_done)
  );

  int total = 0, bad = 0;
  int mode = 0;
  bit gaps = 1'b0, abort = 1'b0;

  logic [15:0] res [H][W][CO];
  int fetch_cnt [H*W];
  int n_out, n_done, n_wwe, seq_err, pix_idx, cur_fetch, ex, ey, ech;

  // Observer: records results, stream order and strobe counts per frame.
  always @(negedge clk) begin
    if (start && !running) begin
      n_out = 0; n_done = 0; n_wwe = 0; seq_err = 0; pix_idx = 0; cur_fetch = 0;
      ex = 0; ey = 0; ech = 0;
    end
    if (int_mem_we) n_wwe++;
    if (overlap_cache_we) cur_fetch++;
    if (data_ready) begin
      if (pix_idx < H * W) fetch_cnt[pix_idx] = cur_fetch;
      cur_fetch = 0;
      pix_idx++;
    end
    if (bus.output_valid) begin
      if (n_out < H * W * CO) begin
        if (int'(bus.output_x) != ex || int'(bus.output_y) != ey || int'(bus.output_ch) != ech)
          seq_err++;
        res[ey][ex][ech] = bus.out;
        ech++;
        if (ech == CO) begin ech = 0; ex++; end
        if (ex == W) begin ex = 0; ey++; end
      end else begin
        seq_err++;
      end
      n_out++;
    end
    if (fsm_done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] img(input int xx, input int yy, input int ci);
    if (mode == 0) return 16'd1;
    if (mode == 1) return (ci == 0) ? 16'(xx + yy) : 16'd7;
    return 16'h7FFF;
  endfunction

  function automatic logic [15:0] wt(input int co, input int ky, input int kx, input int ci);
    if (mode == 0) return 16'd1;
    if (mode == 1) return (ky == 1 && kx == 1 && ci == 0) ? 16'(co) : 16'd0;
    return 16'h7FFF;
  endfunction

  task automatic idle_gap();
    if (gaps && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_b(input logic [15:0] v);
    idle_gap();
    bus.b_input = v;
    bus.b_valid = 1'b1;
    do @(negedge clk); while (!bus.b_ready && !abort);
    @(posedge clk);
    #1 bus.b_valid = 1'b0;
  endtask

  task automatic send_a(input logic [15:0] v);
    idle_gap();
    bus.a_input = v;
    bus.a_valid = 1'b1;
    do @(negedge clk); while (!bus.a_ready && !abort);
    @(posedge clk);
    #1 bus.a_valid = 1'b0;
  endtask

  task automatic feed_w();
    for (int i = 0; i < NW; i++) begin
      if (!abort) send_b(wt(i / TAPS, (i / (CI * K)) % K, (i / CI) % K, i % CI));
    end
  endtask

  // Fetch model: x=0 loads every in-bound tap, x>0 only the new right-hand column.
  task automatic feed_a();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = (x == 0) ? 0 : K - 1; kx < K; kx++)
            for (int ci = 0; ci < CI; ci++) begin
              int yy, xx;
              yy = y + ky - R;
              xx = x + kx - R;
              if (!abort && yy >= 0 && yy < H && xx >= 0 && xx < W) send_a(img(xx, yy, ci));
            end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input int m, input bit g);
    mode = m;
    gaps = g;
    abort = 1'b0;
    pulse_start();
    fork
      feed_w();
      feed_a();
      begin
        int c = 0;
        while (n_done == 0 && c < 20000) begin
          @(negedge clk);
          c++;
        end
        if (n_done == 0) abort = 1'b1;
        check("frame_done_seen", 32'(n_done), 32'd1);
      end
    join
    @(negedge clk);
    check("running_low_after_done", {31'd0, running}, 32'd0);
  endtask

  initial begin
    int errs;
    rst = 1'b1;
    start = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_input = '0;
    bus.b_input = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {24'd0, running, bus.a_ready, bus.b_ready, int_mem_we, overlap_cache_we,
                        data_ready, bus.output_valid, fsm_done}, 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_coords", {24'd0, bus.output_x, bus.output_y, bus.output_ch}, 32'd0);
    #1 rst = 1'b0;

    // Frame A: all ones, no gaps.
    run_frame(0, 1'b0);
    check("a_out_count", 32'(n_out), 32'(H * W * CO));
    check("a_order", 32'(seq_err), 32'd0);
    check("a_w_strobes", 32'(n_wwe), 32'(NW));
    for (int ch = 0; ch < CO; ch++) check("a_interior_5_5", 32'(res[5][5][ch]), 32'd18);
    check("a_corner_0_0", 32'(res[0][0][0]), 32'd8);
    check("a_corner_7_7", 32'(res[7][7][3]), 32'd8);
    check("a_edge_x0_y5", 32'(res[5][0][2]), 32'd12);
    check("a_edge_x4_y0", 32'(res[0][4][1]), 32'd12);
    check("a_fetch_x0_y5", 32'(fetch_cnt[5 * W + 0]), 32'd12);
    check("a_fetch_x1_y5", 32'(fetch_cnt[5 * W + 1]), 32'd6);
    check("a_fetch_x7_y5", 32'(fetch_cnt[5 * W + 7]), 32'd0);
    check("a_fetch_x0_y0", 32'(fetch_cnt[0]), 32'd8);
    check("a_fetch_x3_y0", 32'(fetch_cnt[3]), 32'd4);

    // Abort mid-LOAD_A with the asynchronous reset.
    mode = 0;
    gaps = 1'b0;
    abort = 1'b0;
    pulse_start();
    feed_w();
    repeat (3) send_a(16'd1);
    @(negedge clk);
    check("mid_running", {30'd0, running, bus.a_ready}, 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_flags", {24'd0, running, bus.a_ready, bus.b_ready, int_mem_we, overlap_cache_we,
                          data_ready, bus.output_valid, fsm_done}, 32'd0);
    check("abort_out", 32'(bus.out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Frame B: centre tap weight = co, activation = x+y, random valid gaps.
    run_frame(1, 1'b1);
    check("b_w_reload", 32'(n_wwe), 32'(NW));
    check("b_out_count", 32'(n_out), 32'(H * W * CO));
    check("b_order", 32'(seq_err), 32'd0);
    errs = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int ch = 0; ch < CO; ch++)
          if (res[y][x][ch] !== 16'(ch * (x + y))) errs++;
    check("b_all_pixels", 32'(errs), 32'd0);
    check("b_x3_y2_ch3", 32'(res[2][3][3]), 32'd15);
    check("b_x7_y7_ch2", 32'(res[7][7][2]), 32'd28);
    check("b_x5_y1_ch1", 32'(res[1][5][1]), 32'd6);
    check("b_fetch_x0_y5", 32'(fetch_cnt[5 * W + 0]), 32'd12);

    // Frame C: 0x7FFF * 0x7FFF products wrap the 32-bit sum; output is its low 16 bits.
    run_frame(2, 1'b0);
    check("c_out_count", 32'(n_out), 32'(H * W * CO));
    check("c_interior", 32'(res[5][5][0]), 32'h0012);
    check("c_corner", 32'(res[0][0][1]), 32'h0008);
    check("c_edge", 32'(res[5][0][2]), 32'h000C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
